// File: rtl/stepper_decode_pkg.sv
// Shared definitions for the instruction-cycle sequencer: step encoding,
// opcode values, flag bit positions and the opcode class decoder.
package stepper_decode_pkg;

  // Encoded step register values, S1 is the fetch start / parked step.
  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } step_e;

  // Upper nibble opcodes for non-ALU instructions (IR[7] = 0).
  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_DATA = 4'h2;
  localparam logic [3:0] OP_JMPR = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JCON = 4'h5;
  localparam logic [3:0] OP_CLR  = 4'h6;
  localparam logic [3:0] OP_DISP = 4'h7;

  // Flag register bit positions {C,A,E,Z}.
  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  // One-hot instruction class.
  typedef struct packed {
    logic alu;
    logic ld;
    logic st;
    logic data;
    logic jmpr;
    logic jmp;
    logic jcon;
    logic clr;
    logic disp;
  } op_dec_t;

  // Classify an instruction byte; any IR[7]=1 byte is an ALU operation.
  function automatic op_dec_t decode_op(input logic [7:0] ir);
    op_dec_t d;
    d = '0;
    if (ir[7]) begin
      d.alu = 1'b1;
    end else begin
      case (ir[7:4])
        OP_LD:   d.ld   = 1'b1;
        OP_ST:   d.st   = 1'b1;
        OP_DATA: d.data = 1'b1;
        OP_JMPR: d.jmpr = 1'b1;
        OP_JMP:  d.jmp  = 1'b1;
        OP_JCON: d.jcon = 1'b1;
        OP_CLR:  d.clr  = 1'b1;
        OP_DISP: d.disp = 1'b1;
        default: d      = '0;
      endcase
    end
    return d;
  endfunction

  // Conditional-jump test: any flag selected by the low nibble mask.
  function automatic logic jcon_cond(input logic [3:0] mask, input logic [3:0] flags);
    return (mask[FLAG_C] & flags[FLAG_C]) | (mask[FLAG_A] & flags[FLAG_A]) |
           (mask[FLAG_E] & flags[FLAG_E]) | (mask[FLAG_Z] & flags[FLAG_Z]);
  endfunction

endpackage

// File: rtl/stepper_decode_step_counter.sv
// Six-step sequencer with park-at-boundary halt handling. The step only
// advances on step_en; a halt seen on the S6->S1 edge parks the sequencer
// in S1 until halt drops, and the unpark edge itself never advances.
module step_counter
  import stepper_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en_i,
  input  logic       halt_i,
  output step_e      step_o,
  output logic       halted_o,
  output logic [5:0] seq_o
);

  step_e step_q, step_d;
  logic  halted_q, halted_d;

  // State register: step and parked flag, async reset to S1 / running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= S1;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: parked state ignores step_en; otherwise advance on step_en.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d   = S1;
      halted_d = halt_i;
    end else if (step_en_i) begin
      halted_d = 1'b0;
      case (step_q)
        S1:      step_d = S2;
        S2:      step_d = S3;
        S3:      step_d = S4;
        S4:      step_d = S5;
        S5:      step_d = S6;
        S6: begin
          step_d   = S1;
          halted_d = halt_i;
        end
        default: step_d = S1;
      endcase
    end else begin
      step_d   = step_q;
      halted_d = halted_q;
    end
  end

  // Output decode: exactly one step line high; stray codes read as S1.
  always_comb begin
    seq_o = 6'b00_0001;
    case (step_q)
      S1:      seq_o = 6'b00_0001;
      S2:      seq_o = 6'b00_0010;
      S3:      seq_o = 6'b00_0100;
      S4:      seq_o = 6'b00_1000;
      S5:      seq_o = 6'b01_0000;
      S6:      seq_o = 6'b10_0000;
      default: seq_o = 6'b00_0001;
    endcase
  end

  assign step_o   = step_q;
  assign halted_o = halted_q;

endmodule

// File: rtl/stepper_decode.sv
// Instruction-cycle sequencer top: step counter, IR latch at the end of
// fetch, and step-qualified control strobes decoded from IR.
module stepper_decode
  import stepper_decode_pkg::*;
#(
  parameter int NSTEP = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  input  logic       halt,
  input  logic [7:0] ir_in,
  input  logic [3:0] flags,
  output logic       seq1,
  output logic       seq2,
  output logic       seq3,
  output logic       seq4,
  output logic       seq5,
  output logic       seq6,
  output logic [7:0] ir,
  output logic       halted,
  output logic       cpt4,
  output logic       cpt5,
  output logic       cpt6,
  output logic       LD4,
  output logic       LD5,
  output logic       ST4,
  output logic       ST5,
  output logic       DATA4,
  output logic       DATA5,
  output logic       DATA6,
  output logic       JMPR4,
  output logic       JMP4,
  output logic       JMP5,
  output logic       JCON4,
  output logic       JCON5,
  output logic       JCON6,
  output logic       CLR4,
  output logic       DISP4
);

  step_e            step_s;
  logic [NSTEP-1:0] seq_s;
  logic [7:0]       ir_q, ir_d;
  op_dec_t          dec_s;
  logic             cond_s;

  step_counter u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_en_i (step_en),
    .halt_i    (halt),
    .step_o    (step_s),
    .halted_o  (halted),
    .seq_o     (seq_s)
  );

  // IR next value: capture the bus on the step-3 advance edge, else hold.
  always_comb begin
    if ((step_s == S3) && step_en) begin
      ir_d = ir_in;
    end else begin
      ir_d = ir_q;
    end
  end

  // IR register, cleared by reset so it decodes as LD (no step-1..3 strobes).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= 8'h00;
    end else begin
      ir_q <= ir_d;
    end
  end

  assign dec_s  = decode_op(ir_q);
  assign cond_s = jcon_cond(ir_q[3:0], flags);

  assign {seq6, seq5, seq4, seq3, seq2, seq1} = seq_s;
  assign ir = ir_q;

  assign cpt4  = dec_s.alu  & seq_s[3];
  assign cpt5  = dec_s.alu  & seq_s[4];
  assign cpt6  = dec_s.alu  & seq_s[5];
  assign LD4   = dec_s.ld   & seq_s[3];
  assign LD5   = dec_s.ld   & seq_s[4];
  assign ST4   = dec_s.st   & seq_s[3];
  assign ST5   = dec_s.st   & seq_s[4];
  assign DATA4 = dec_s.data & seq_s[3];
  assign DATA5 = dec_s.data & seq_s[4];
  assign DATA6 = dec_s.data & seq_s[5];
  assign JMPR4 = dec_s.jmpr & seq_s[3];
  assign JMP4  = dec_s.jmp  & seq_s[3];
  assign JMP5  = dec_s.jmp  & seq_s[4];
  // Steps 4/5 of JCON run unconditionally to keep the +1 fall-through path.
  assign JCON4 = dec_s.jcon & seq_s[3];
  assign JCON5 = dec_s.jcon & seq_s[4];
  assign JCON6 = dec_s.jcon & seq_s[5] & cond_s;
  assign CLR4  = dec_s.clr  & seq_s[3];
  assign DISP4 = dec_s.disp & seq_s[3];

endmodule

// File: tb/tb_stepper_decode.sv
// Scoreboard bench for stepper_decode: a step-number based reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_stepper_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_en = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] ir_in = 8'h00;
  logic [3:0] flags = 4'h0;
  logic seq1, seq2, seq3, seq4, seq5, seq6, halted;
  logic [7:0] ir;
  logic cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6;
  logic JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4;

  stepper_decode dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .halt(halt),
    .ir_in(ir_in), .flags(flags),
    .seq1(seq1), .seq2(seq2), .seq3(seq3), .seq4(seq4), .seq5(seq5), .seq6(seq6),
    .ir(ir), .halted(halted),
    .cpt4(cpt4), .cpt5(cpt5), .cpt6(cpt6), .LD4(LD4), .LD5(LD5), .ST4(ST4), .ST5(ST5),
    .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6), .JMPR4(JMPR4), .JMP4(JMP4), .JMP5(JMP5),
    .JCON4(JCON4), .JCON5(JCON5), .JCON6(JCON6), .CLR4(CLR4), .DISP4(DISP4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  seq;
    logic [7:0]  ir;
    logic        halted;
    logic [17:0] str;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: plain step number 1..6.
  int         m_step = 1;
  logic [7:0] m_ir = 8'h00;
  logic       m_halted = 1'b0;

  // Strobe order (bit 17 down to 0):
  // cpt4 cpt5 cpt6 LD4 LD5 ST4 ST5 DATA4 DATA5 DATA6 JMPR4 JMP4 JMP5 JCON4 JCON5 JCON6 CLR4 DISP4
  function automatic logic [17:0] model_strobes(input int step, input logic [7:0] i, input logic [3:0] f);
    logic [17:0] s;
    int base;
    int n;
    s = 18'd0;
    if (i[7]) begin base = 17; n = 3; end
    else begin
      case (int'(i[6:4]))
        0: begin base = 14; n = 2; end
        1: begin base = 12; n = 2; end
        2: begin base = 10; n = 3; end
        3: begin base = 7;  n = 1; end
        4: begin base = 6;  n = 2; end
        5: begin base = 4;  n = 3; end
        6: begin base = 1;  n = 1; end
        default: begin base = 0; n = 1; end
      endcase
    end
    if (step >= 4 && (step - 4) < n) begin
      if (!(i[7:4] == 4'h5 && step == 6 && (i[3:0] & f) == 4'h0))
        s[base - (step - 4)] = 1'b1;
    end
    return s;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [5:0] one;
    one = 6'd1;
    e.seq    = one << (m_step - 1);
    e.ir     = m_ir;
    e.halted = m_halted;
    e.str    = model_strobes(m_step, m_ir, flags);
    return e;
  endfunction

  task automatic model_reset();
    m_step = 1; m_ir = 8'h00; m_halted = 1'b0;
  endtask

  // Clock-edge behaviour of the sequencer as described in words.
  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (m_halted) begin
      if (!halt) m_halted = 1'b0;
    end else if (step_en) begin
      if (m_step == 3) m_ir = ir_in;
      if (m_step == 6) begin
        m_step = 1;
        m_halted = halt;
      end else m_step = m_step + 1;
    end
  endtask

  task automatic compare(input exp_t e, input string tag);
    logic [5:0]  g_seq;
    logic [17:0] g_str;
    g_seq = {seq6, seq5, seq4, seq3, seq2, seq1};
    g_str = {cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6,
             JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4};
    checks = checks + 4;
    if (g_seq !== e.seq) begin
      failures++; $display("FAIL %s seq t=%0t got=%b exp=%b", tag, $time, g_seq, e.seq);
    end
    if (ir !== e.ir) begin
      failures++; $display("FAIL %s ir t=%0t got=%h exp=%h", tag, $time, ir, e.ir);
    end
    if (halted !== e.halted) begin
      failures++; $display("FAIL %s halted t=%0t got=%b exp=%b", tag, $time, halted, e.halted);
    end
    if (g_str !== e.str) begin
      failures++; $display("FAIL %s strobes t=%0t got=%b exp=%b", tag, $time, g_str, e.str);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e, "mon");
      end
    end
  end

  // One cycle of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic tick(input logic r, input logic en, input logic h,
                      input logic [7:0] d, input logic [3:0] f);
    @(negedge clk);
    #2;
    rst_n = r; step_en = en; halt = h; ir_in = d; flags = f;
    @(posedge clk);
    model_edge();
    #1;
    q.push_back(model_out());
  endtask

  task automatic run_instr(input logic [7:0] d, input logic [3:0] f);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, d, f);
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rf;
    // Reset held while step_en toggles, then release and walk six steps.
    for (int i = 0; i < 4; i++) tick(1'b0, i[0], 1'b0, 8'hFF, 4'hF);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    run_instr(8'h00, 4'h0);
    // ALU, JCON taken / not taken, then DATA with a stall in S5.
    run_instr(8'h85, 4'h0);
    run_instr(8'h52, 4'b0010);
    run_instr(8'h52, 4'b0000);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 8'h20, 4'h0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'h20, 4'h0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0, 8'h20, 4'h0);
    // Halt raised at S4 of a JMP: completes, parks, ignores step_en, unparks.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 8'h40, 4'h0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 8'h40, 4'h0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 8'h40, 4'h0);
    tick(1'b1, 1'b1, 1'b0, 8'h40, 4'h0);
    tick(1'b1, 1'b1, 1'b0, 8'h40, 4'h0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
    // ST to S5, then asynchronous reset in the middle of the cycle.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 8'h10, 4'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare(model_out(), "async_rst");
    tick(1'b0, 1'b1, 1'b0, 8'h10, 4'h0);
    tick(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    // Random traffic, covering every opcode, stalls, halts and rare resets.
    for (int i = 0; i < 600; i++) begin
      rd = 8'($urandom());
      rf = 4'($urandom());
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), rd, rf);
    end
    @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
